dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the CPU MEM stage (port C) and a DMA/debug loader (port D).
- Sits between the MEM-stage pipeline register and the data memory plus memory-mapped I/O.
- Stalls the CPU while the memory is busy or a read is in flight.
- Fixed priority to the CPU, with a starvation guard that forces a DMA grant after STARVE_MAX lost cycles.

Parameters:
- AW, 32, address width of both requesters and the memory port
- DW, 32, data width
- STARVE_MAX, 4, consecutive lost arbitration cycles after which DMA wins (range 1..15)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  MEM stage wants an access; held until cpu_stall=0
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  byte address (malu)
- cpu_wdata  in  DW  store data (mb)
- cpu_rdata  out  DW  load data (mmo)
- cpu_stall  out  1  freeze IF..MEM stages this cycle
- dma_req  in  1  DMA wants an access; held until dma_ack
- dma_we  in  1  1=write, 0=read
- dma_addr  in  AW  byte address
- dma_wdata  in  DW  write data
- dma_rdata  out  DW  read data, valid with dma_ack on reads
- dma_ack  out  1  one-cycle completion pulse
- mem_addr  out  AW  to data memory
- mem_wdata  out  DW  to data memory
- mem_we  out  1  write strobe, sampled at the rising clock edge
- mem_rdata  in  DW  memory read data, valid one cycle after address

Behaviour:
- Reset (async, high):
  - state=IDLE, starve_cnt=0.
  - cpu_rdata and dma_rdata registers = 0.
  - mem_we=0, dma_ack=0.
  - Any in-flight read is discarded, with no ack or data.
- States:
  - IDLE: arbitration and address phase.
  - CPU_RD: data phase of a CPU read.
  - DMA_RD: data phase of a DMA read.
- IDLE grant rule, evaluated combinationally each cycle:
  - DMA wins if dma_req && (!cpu_req || starve_cnt==STARVE_MAX).
  - Otherwise CPU wins if cpu_req.
  - Otherwise no grant: mem_we=0 and mem_addr/mem_wdata hold their last values (don't care).
- Grant in IDLE drives the winner's address, wdata and we onto the mem_* outputs in the same cycle.
- Write grant:
  - Completes in that cycle.
  - CPU winner: cpu_stall=0.
  - DMA winner: dma_ack=1.
  - State stays IDLE.
- Read grant:
  - Goes to CPU_RD or DMA_RD; mem_we=0.
  - CPU winner: cpu_stall=1 in the grant cycle.
- CPU_RD:
  - cpu_rdata = mem_rdata (combinational pass-through); mem_rdata is also latched into the cpu_rdata register.
  - cpu_stall=0, mem_we=0, no new grant; next state IDLE.
  - Outside CPU_RD, cpu_rdata = the held register.
- DMA_RD:
  - dma_rdata = mem_rdata (pass-through) and latched; dma_ack=1.
  - cpu_stall = cpu_req; no new grant; next state IDLE.
- cpu_stall formula:
  - cpu_stall = cpu_req && !(state==CPU_RD || (state==IDLE && CPU granted && cpu_we)).
  - cpu_stall=0 whenever cpu_req=0.
- CPU timing:
  - Read latency: 2 cycles (1 stall cycle).
  - Write latency: 1 cycle when uncontended.
- DMA timing:
  - Write ack in the grant cycle.
  - Read ack 1 cycle after grant.
- starve_cnt:
  - Cleared on a DMA grant or when dma_req=0.
  - Otherwise +1 on each cycle where dma_req=1 and DMA is not granted (including CPU_RD cycles); saturates at STARVE_MAX.
- Simultaneous requests:
  - With starve_cnt<STARVE_MAX, the CPU wins.
  - At STARVE_MAX, DMA wins exactly once; the counter then clears.
- A requester that drops req without completing is an illegal protocol; the only requirement is that the block never hangs.
- No address decoding: I/O ports are reached through the same mem_* path.
- Back-to-back CPU writes with no DMA sustain 1 access per cycle.

Decomposition:
- Shared package:
  - State enum (IDLE, CPU_RD, DMA_RD).
  - Grant-select constants (GNT_NONE, GNT_CPU, GNT_DMA).
  - Default widths 32.
- Natural sub-module: dmem_starve_ctr, the saturating starvation counter with clear/increment inputs and an at_max output.
- The FSM and mux stay in the top level.

Test Plan:
- Reset mid-read: CPU read of 0x10 granted, reset asserted in CPU_RD -> state IDLE, cpu_rdata=0, mem_we=0, no dma_ack.
- CPU load: mem[0x20]=0xDEADBEEF; cpu_req=1, we=0, addr=0x20 -> cycle0 cpu_stall=1, mem_addr=0x20; cycle1 cpu_stall=0, cpu_rdata=0xDEADBEEF.
- CPU store: addr=0x24, wdata=0x12345678 -> same cycle mem_we=1, cpu_stall=0; a later CPU read of 0x24 returns 0x12345678.
- DMA write with CPU idle: dma_addr=0x40, wdata=0xA5A5A5A5 -> dma_ack=1 in the same cycle, mem_we=1.
- Starvation, STARVE_MAX=4: continuous CPU writes plus dma_req read of 0x40:
  - CPU gets 4 grants.
  - 5th cycle: DMA granted, cpu_stall=1.
  - Next cycle: dma_ack=1, dma_rdata=0xA5A5A5A5, starve_cnt=0.
- Simultaneous CPU read and DMA read, starve_cnt=0:
  - CPU granted first (2 cycles).
  - DMA granted in the following IDLE cycle.
  - dma_ack arrives 1 cycle after that grant.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  // Wide enough for the largest legal starvation limit (15)
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } gnt_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of arbitration cycles lost by the DMA port.
// Latency: at_max reflects the count registered on the previous edge.
// Backpressure: none; clr wins over inc, the count holds at MAX.
module dmem_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [CNT_W-1:0] cnt;

  assign at_max = (cnt == CNT_W'(MAX));

  // Clear dominates; increment stops once the limit is reached
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data memory between CPU MEM stage and DMA.
// Latency: writes complete in the grant cycle; reads return one cycle later.
// Backpressure: CPU held by cpu_stall, DMA waits for dma_ack; CPU has priority
// until the DMA has lost STARVE_MAX consecutive cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state;
  gnt_t          gnt;
  logic          at_max;
  logic          starve_clr;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;

  // Arbitration only happens in IDLE; reset suppresses any grant so no
  // write strobe or ack can leak out while the block is held in reset
  always_comb begin
    gnt = GNT_NONE;
    if (state == IDLE && !reset) begin
      if (dma_req && (!cpu_req || at_max)) begin
        gnt = GNT_DMA;
      end else if (cpu_req) begin
        gnt = GNT_CPU;
      end
    end
  end

  // Route the winner onto the memory port; address/data are don't-care
  // when nothing is granted, so the CPU side is left on the bus
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    case (gnt)
      GNT_CPU: mem_we = cpu_we;
      GNT_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
      end
      default: ;
    endcase
  end

  // Access sequencer: a read grant moves to its data phase, which
  // captures the memory output and always returns to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt == GNT_CPU && !cpu_we) begin
            state <= CPU_RD;
          end else if (gnt == GNT_DMA && !dma_we) begin
            state <= DMA_RD;
          end
        end
        CPU_RD: begin
          cpu_rdata_q <= mem_rdata;
          state       <= IDLE;
        end
        DMA_RD: begin
          dma_rdata_q <= mem_rdata;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data passes straight through during its data phase so the
  // requester can use it in the completion cycle
  assign cpu_rdata = (state == CPU_RD) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (state == DMA_RD) ? mem_rdata : dma_rdata_q;

  assign cpu_stall = cpu_req &&
                     !((state == CPU_RD) || (gnt == GNT_CPU && cpu_we));
  assign dma_ack   = (gnt == GNT_DMA && dma_we) || (state == DMA_RD);

  // The DMA data phase belongs to the DMA access itself, so it is not a
  // lost cycle; every other cycle with dma_req pending and no grant is
  assign starve_clr = !dma_req || (gnt == GNT_DMA) || (state == DMA_RD);

  dmem_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clock  (clock),
    .reset  (reset),
    .clr    (starve_clr),
    .inc    (dma_req),
    .at_max (at_max)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// scored against a shadow memory and per-access latency bounds.
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];

  always #5 clock = ~clock;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_val(int i);
    return (i == 8) ? 32'hDEADBEEF : 32'(i) * 32'h01010101;
  endfunction

  // Synchronous single-port memory: data one cycle after the address
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Randomized-phase requester bookkeeping
  logic        c_act, c_we_r, d_act, d_we_r;
  logic [5:0]  c_idx, d_idx;
  logic [31:0] c_dat, d_dat;
  int          c_wait, d_wait;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(posedge clock);

    // Reset state
    @(negedge clock);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_cpu_stall", cpu_stall, 0);

    // Reset in the middle of a CPU read
    drive_edge();
    reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clock);
    chk("midrd_grant_stall", cpu_stall, 1);
    chk("midrd_grant_addr", mem_addr, 32'h10);
    drive_edge();
    reset = 1; cpu_req = 0;
    @(negedge clock);
    chk("midrd_cpu_rdata", cpu_rdata, 0);
    chk("midrd_mem_we", mem_we, 0);
    chk("midrd_dma_ack", dma_ack, 0);
    drive_edge();
    reset = 0;

    // CPU load (a stall here also proves the FSM returned to IDLE)
    drive_edge();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    @(negedge clock);
    chk("ld_c0_stall", cpu_stall, 1);
    chk("ld_c0_addr", mem_addr, 32'h20);
    chk("ld_c0_we", mem_we, 0);
    drive_edge();
    @(negedge clock);
    chk("ld_c1_stall", cpu_stall, 0);
    chk("ld_c1_rdata", cpu_rdata, 32'hDEADBEEF);
    drive_edge();
    cpu_req = 0;
    @(negedge clock);
    chk("ld_held_rdata", cpu_rdata, 32'hDEADBEEF);

    // CPU store then read back
    drive_edge();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = 32'h12345678;
    @(negedge clock);
    chk("st_we", mem_we, 1);
    chk("st_stall", cpu_stall, 0);
    chk("st_wdata", mem_wdata, 32'h12345678);
    drive_edge();
    cpu_we = 0;
    @(negedge clock);
    chk("st_rd_c0_stall", cpu_stall, 1);
    drive_edge();
    @(negedge clock);
    chk("st_rd_c1_rdata", cpu_rdata, 32'h12345678);
    drive_edge();
    cpu_req = 0;

    // DMA write with CPU idle
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hA5A5A5A5;
    @(negedge clock);
    chk("dwr_ack", dma_ack, 1);
    chk("dwr_we", mem_we, 1);
    chk("dwr_addr", mem_addr, 32'h40);
    drive_edge();
    dma_req = 0;
    @(negedge clock);
    chk("dwr_ack_drop", dma_ack, 0);

    // Starvation guard: continuous CPU writes against a DMA read
    drive_edge();
    dma_req = 1; dma_we = 0; dma_addr = 32'h40;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'd1;
    for (int i = 0; i < SMAX; i++) begin
      @(negedge clock);
      chk("stv_cpu_stall", cpu_stall, 0);
      chk("stv_cpu_addr", mem_addr, 32'h80 + 32'(4 * i));
      chk("stv_dma_ack", dma_ack, 0);
      drive_edge();
      cpu_addr = 32'h80 + 32'(4 * (i + 1));
      cpu_wdata = 32'(i + 2);
    end
    @(negedge clock);
    chk("stv_dgnt_stall", cpu_stall, 1);
    chk("stv_dgnt_addr", mem_addr, 32'h40);
    chk("stv_dgnt_we", mem_we, 0);
    chk("stv_dgnt_ack", dma_ack, 0);
    drive_edge();
    @(negedge clock);
    chk("stv_dack", dma_ack, 1);
    chk("stv_drdata", dma_rdata, 32'hA5A5A5A5);
    chk("stv_dack_stall", cpu_stall, 1);
    drive_edge();
    dma_req = 0;
    @(negedge clock);
    chk("stv_cpu_resume", cpu_stall, 0);
    chk("stv_resume_addr", mem_addr, 32'h80 + 32'(4 * SMAX));
    drive_edge();
    cpu_req = 0;

    // Simultaneous CPU read and DMA read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dma_req = 1; dma_we = 0; dma_addr = 32'h24;
    @(negedge clock);
    chk("sim_c0_addr", mem_addr, 32'h20);
    chk("sim_c0_stall", cpu_stall, 1);
    chk("sim_c0_ack", dma_ack, 0);
    drive_edge();
    @(negedge clock);
    chk("sim_c1_stall", cpu_stall, 0);
    chk("sim_c1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("sim_c1_ack", dma_ack, 0);
    drive_edge();
    cpu_req = 0;
    @(negedge clock);
    chk("sim_c2_addr", mem_addr, 32'h24);
    chk("sim_c2_ack", dma_ack, 0);
    drive_edge();
    @(negedge clock);
    chk("sim_c3_ack", dma_ack, 1);
    chk("sim_c3_rdata", dma_rdata, 32'h12345678);
    drive_edge();
    dma_req = 0;

    // Randomized traffic: shadow memory tracks completed writes
    for (int i = 0; i < 64; i++) shadow[i] = mem[i];
    c_act = 0; d_act = 0; c_wait = 0; d_wait = 0;
    c_we_r = 0; d_we_r = 0; c_idx = '0; d_idx = '0; c_dat = '0; d_dat = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!c_act && $urandom_range(0, 99) < 60) begin
        c_act = 1; c_wait = 0;
        c_we_r = 1'($urandom); c_idx = 6'($urandom); c_dat = $urandom;
      end
      if (!d_act && $urandom_range(0, 99) < 40) begin
        d_act = 1; d_wait = 0;
        d_we_r = 1'($urandom); d_idx = 6'($urandom); d_dat = $urandom;
      end
      cpu_req = c_act; cpu_we = c_we_r; cpu_addr = {24'd0, c_idx, 2'b00}; cpu_wdata = c_dat;
      dma_req = d_act; dma_we = d_we_r; dma_addr = {24'd0, d_idx, 2'b00}; dma_wdata = d_dat;
      @(negedge clock);
      if (c_act) begin
        c_wait++;
        if (!cpu_stall) begin
          if (c_we_r) begin
            chk("rnd_cpu_wr_we", mem_we, 1);
            chk("rnd_cpu_wr_addr", mem_addr, {24'd0, c_idx, 2'b00});
            shadow[c_idx] = c_dat;
          end else begin
            chk("rnd_cpu_rd", cpu_rdata, shadow[c_idx]);
          end
          chk("rnd_cpu_lat", 32'(c_wait <= (c_we_r ? 3 : 4)), 1);
          c_act = 0;
        end else if (c_wait > 40) begin
          chk("rnd_cpu_hang", 0, 1);
          c_act = 0;
        end
      end else begin
        chk("rnd_cpu_idle_stall", cpu_stall, 0);
      end
      if (d_act) begin
        d_wait++;
        if (dma_ack) begin
          if (d_we_r) begin
            chk("rnd_dma_wr_we", mem_we, 1);
            chk("rnd_dma_wr_data", mem_wdata, d_dat);
            shadow[d_idx] = d_dat;
          end else begin
            chk("rnd_dma_rd", dma_rdata, shadow[d_idx]);
          end
          chk("rnd_dma_lat", 32'(d_wait <= (d_we_r ? SMAX + 2 : SMAX + 3)), 1);
          d_act = 0;
        end else if (d_wait > 40) begin
          chk("rnd_dma_hang", 0, 1);
          d_act = 0;
        end
      end else begin
        chk("rnd_dma_idle_ack", dma_ack, 0);
      end
      drive_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
